// File: rtl/tapavg_ctrl.sv
// tapavg_ctrl: averages the last DEPTH tap periods with a serial restoring divider and offers the result with a valid/ready handshake
module tapavg_ctrl #(
  parameter int DEPTH = 4,
  parameter int PER_WIDTH = 17,
  parameter int TIMEOUT_TP = 65535
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         tp_i,
  input  logic [PER_WIDTH-1:0]         btn_per_i,
  input  logic                         btn_per_valid,
  output logic [PER_WIDTH-1:0]         avg_per_o,
  output logic                         avg_valid_o,
  input  logic                         avg_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   hist_cnt_o,
  output logic                         drop_o
);
  localparam int LW = $clog2(DEPTH);
  localparam int SW = PER_WIDTH + LW;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_TP + 1);
  localparam int BW = $clog2(SW);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, CALC = 2'd2, OFFER = 2'd3;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TP);
  localparam logic [BW-1:0] LAST = BW'(SW - 1);
  logic [1:0] state;
  logic [PER_WIDTH-1:0] hist [DEPTH];
  logic [LW-1:0] wp;
  logic [SW-1:0] sum, dq, sum_nx, dq_nx;
  logic [CW-1:0] rem, rem_sub;
  logic [CW:0] rem_sh;
  logic [BW-1:0] bit_cnt;
  logic [PER_WIDTH-1:0] pend_val, ld_val, evicted;
  logic pend_v, consume, timeout, sat, ge, clr;
  logic [TW-1:0] tp_cnt;
  always_comb begin
    consume = state == IDLE && pend_v;
    timeout = tp_cnt == TMAX;
    sat = &ld_val;
    clr = (state == IDLE && timeout) || (state == LOAD && sat);
    evicted = hist_cnt_o == FULL ? hist[wp] : '0;
    sum_nx = sum + SW'(ld_val) - SW'(evicted);
    rem_sh = {rem, dq[SW-1]};
    ge = rem_sh >= {1'b0, hist_cnt_o};
    rem_sub = rem_sh[CW-1:0] - hist_cnt_o;
    dq_nx = {dq[SW-2:0], ge};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      wp <= '0;
      sum <= '0;
      dq <= '0;
      rem <= '0;
      bit_cnt <= '0;
      pend_val <= '0;
      ld_val <= '0;
      pend_v <= 1'b0;
      tp_cnt <= '0;
      avg_per_o <= '0;
      avg_valid_o <= 1'b0;
      hist_cnt_o <= '0;
      drop_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      drop_o <= btn_per_valid && pend_v && !consume;
      if (btn_per_valid) begin
        pend_val <= btn_per_i;
        pend_v <= 1'b1;
      end else if (consume) pend_v <= 1'b0;
      tp_cnt <= btn_per_valid ? '0 : (tp_i && !timeout) ? tp_cnt + TW'(1) : tp_cnt;
      case (state)
        IDLE: if (pend_v) begin
          ld_val <= pend_val;
          state <= LOAD;
        end
        LOAD: if (sat) state <= IDLE;
        else begin
          hist[wp] <= ld_val;
          wp <= wp + LW'(1);
          sum <= sum_nx;
          hist_cnt_o <= hist_cnt_o == FULL ? FULL : hist_cnt_o + CW'(1);
          dq <= sum_nx;
          rem <= '0;
          bit_cnt <= '0;
          state <= CALC;
        end
        CALC: begin
          dq <= dq_nx;
          rem <= ge ? rem_sub : rem_sh[CW-1:0];
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_cnt == LAST) begin
            avg_per_o <= dq_nx[PER_WIDTH-1:0];
            avg_valid_o <= 1'b1;
            state <= OFFER;
          end
        end
        default: if (avg_ready_i) begin
          avg_valid_o <= 1'b0;
          state <= IDLE;
        end
      endcase
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        wp <= '0;
        sum <= '0;
        hist_cnt_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_tapavg_ctrl.sv
// tb_tapavg_ctrl: directed and randomized checks of tapavg_ctrl against a queue-based reference model
module tb_tapavg_ctrl;
  localparam int DEPTH = 4, PW = 17, TO = 10, SW = PW + 2;
  localparam int ALL1 = (1 << PW) - 1;
  logic clk = 1'b0, rst_i = 1'b1, tp_i = 1'b0, btn_per_valid = 1'b0, avg_ready_i = 1'b1;
  logic [PW-1:0] btn_per_i = '0;
  logic [PW-1:0] avg_per_o;
  logic avg_valid_o, drop_o;
  logic [2:0] hist_cnt_o;
  int n_cmp = 0, n_err = 0, cyc = 0, n_drop = 0;
  bit chk_en = 1'b0;
  int m_ph = 0, m_cnt = 0, m_pend = 0, m_ld = 0, m_avg = 0, m_next = 0, m_tp = 0;
  bit m_pv = 1'b0, m_valid = 1'b0, m_drop = 1'b0;
  int m_hist[$];
  int got_v[$], got_h[$];

  tapavg_ctrl #(.DEPTH(DEPTH), .PER_WIDTH(PW), .TIMEOUT_TP(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .tp_i(tp_i), .btn_per_i(btn_per_i),
    .btn_per_valid(btn_per_valid), .avg_per_o(avg_per_o), .avg_valid_o(avg_valid_o),
    .avg_ready_i(avg_ready_i), .hist_cnt_o(hist_cnt_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: history as a queue, average by plain integer division,
  // timing as phase countdowns (idle / load / divide / offer).
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_i && avg_valid_o && avg_ready_i) begin
      got_v.push_back(int'(avg_per_o));
      got_h.push_back(int'(hist_cnt_o));
    end
    if (rst_i) begin
      m_ph = 0; m_cnt = 0; m_pend = 0; m_ld = 0; m_avg = 0; m_tp = 0;
      m_pv = 0; m_valid = 0; m_drop = 0;
      m_hist.delete();
    end else begin
      automatic bit idle_take = (m_ph == 0) && m_pv;
      automatic int s = 0;
      m_drop = btn_per_valid && m_pv && !idle_take;
      case (m_ph)
        0: begin
          if (m_tp == TO) m_hist.delete();
          if (m_pv) begin m_ld = m_pend; m_ph = 1; end
        end
        1: if (m_ld == ALL1) begin
          m_hist.delete();
          m_ph = 0;
        end else begin
          m_hist.push_back(m_ld);
          if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
          foreach (m_hist[k]) s += m_hist[k];
          m_next = s / m_hist.size();
          m_cnt = SW;
          m_ph = 2;
        end
        2: begin
          m_cnt--;
          if (m_cnt == 0) begin m_avg = m_next; m_valid = 1; m_ph = 3; end
        end
        default: if (avg_ready_i) begin m_valid = 0; m_ph = 0; end
      endcase
      if (btn_per_valid) begin m_pend = int'(btn_per_i); m_pv = 1; end
      else if (idle_take) m_pv = 0;
      m_tp = btn_per_valid ? 0 : (tp_i && m_tp < TO) ? m_tp + 1 : m_tp;
    end
  end

  initial forever begin
    @(negedge clk);
    if (drop_o) n_drop++;
    if (chk_en) begin
      check("valid", avg_valid_o, m_valid);
      check("avg_per", avg_per_o, m_avg);
      check("hist_cnt", hist_cnt_o, m_hist.size());
      check("drop", drop_o, m_drop);
    end
  end

  task automatic tap(int v);
    @(negedge clk);
    btn_per_i = PW'(v);
    btn_per_valid = 1'b1;
    @(negedge clk);
    btn_per_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic wait_out(string name, output int v, output int h);
    int n0 = got_v.size();
    for (int i = 0; i < 300 && got_v.size() == n0; i++) @(negedge clk);
    if (got_v.size() == n0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: no output within 300 cycles", name);
      v = -1; h = -1;
    end else begin
      v = got_v[$]; h = got_h[$];
    end
  endtask

  task automatic wait_valid(string name);
    for (int i = 0; i < 100 && !avg_valid_o; i++) @(negedge clk);
    if (!avg_valid_o) begin
      n_cmp++; n_err++;
      $display("FAIL %s: avg_valid_o never rose", name);
    end
  endtask

  initial begin
    int v, h, c0, n0, bad;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    chk_en = 1'b1;
    check("reset_valid", avg_valid_o, 0);
    check("reset_avg", avg_per_o, 0);
    check("reset_hist", hist_cnt_o, 0);
    check("reset_drop", drop_o, 0);

    @(negedge clk);
    btn_per_i = 17'd100; btn_per_valid = 1'b1; c0 = cyc;
    @(negedge clk);
    btn_per_valid = 1'b0;
    wait_valid("latency_wait");
    check("latency", cyc - c0, 22);
    wait_out("seq3_1", v, h); check("seq3_out1", v, 100); check("seq3_hist1", h, 1);
    tap(200); wait_out("seq3_2", v, h); check("seq3_out2", v, 150); check("seq3_hist2", h, 2);
    tap(300); wait_out("seq3_3", v, h); check("seq3_out3", v, 200); check("seq3_hist3", h, 3);

    do_reset();
    for (int i = 1; i <= 5; i++) begin
      tap(100 * i); wait_out("seq5", v, h);
      if (i >= 4) check("seq5_hist", h, 4);
    end
    check("seq5_out5", v, 350);

    do_reset();
    avg_ready_i = 1'b0;
    tap(700);
    wait_valid("hold_wait");
    n0 = got_v.size(); bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (avg_valid_o !== 1'b1 || avg_per_o !== 17'd700) bad++;
    end
    check("hold_stable", bad, 0);
    check("hold_no_xfer", got_v.size() - n0, 0);
    avg_ready_i = 1'b1;
    wait_out("hold_xfer", v, h); check("hold_out", v, 700);
    repeat (10) @(negedge clk);
    check("hold_single", got_v.size() - n0, 1);

    do_reset();
    tap(400);
    repeat (5) @(negedge clk);
    n_drop = 0;
    @(negedge clk); btn_per_i = 17'd1000; btn_per_valid = 1'b1;
    @(negedge clk); btn_per_i = 17'd2000;
    @(negedge clk); btn_per_valid = 1'b0;
    wait_out("drop_1", v, h); check("drop_out1", v, 400);
    wait_out("drop_2", v, h); check("drop_out2", v, 1200);
    check("drop_pulses", n_drop, 1);

    do_reset();
    repeat (4) begin tap(500); wait_out("sat_fill", v, h); check("sat_fill_out", v, 500); end
    n0 = got_v.size();
    tap(ALL1);
    repeat (40) @(negedge clk);
    check("sat_no_out", got_v.size() - n0, 0);
    check("sat_hist", hist_cnt_o, 0);
    tap(800); wait_out("sat_next", v, h); check("sat_next_out", v, 800); check("sat_next_hist", h, 1);

    repeat (3) @(negedge clk);
    check("to_before", hist_cnt_o, 1);
    repeat (11) begin
      @(negedge clk); tp_i = 1'b1;
      @(negedge clk); tp_i = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("to_hist", hist_cnt_o, 0);

    tap(300);
    repeat (8) @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    bad = 0;
    repeat (40) begin @(negedge clk); if (avg_valid_o !== 1'b0) bad++; end
    check("rst_abort", bad, 0);

    for (int c = 0; c < 4000; c++) begin
      int r;
      @(negedge clk);
      r = int'($urandom_range(0, 15));
      btn_per_valid = ($urandom_range(0, 15) == 0);
      btn_per_i = r == 0 ? PW'(ALL1) : r == 1 ? PW'(ALL1 - 1) : PW'($urandom_range(0, 3000));
      tp_i = ($urandom_range(0, 1) == 0);
      avg_ready_i = ($urandom_range(0, 2) != 0);
      rst_i = (c >= 2000 && c < 2002);
    end
    @(negedge clk);
    btn_per_valid = 1'b0; tp_i = 1'b0; avg_ready_i = 1'b1; rst_i = 1'b0;
    repeat (60) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
